mbgd_dot_sched: RTL and testbench
=================================

# mbgd_dot_sched

Batch scheduler for the mini-batch gradient descent (MBGD) dot-product engine. On `start` it latches the weight vector theta and a batch size. It then streams one sample feature vector per cycle from sample memory into the pipelined dot-product engine and writes each returned result to the result buffer at the sample's index. It sits between the MBGD top-level control and the dot-product datapath, and is the only issuer of `dp_enable`.

## Interface
- DATA_WIDTH, 8, bits per vector element
- NUM_ELEMS, 8, elements per vector; vector width VW = DATA_WIDTH*NUM_ELEMS = 64
- ACC_WIDTH, 19, dot-product result width (2*DATA_WIDTH + 3)
- BATCH_MAX, 19, maximum samples per batch
- ADDR_W, 5, sample/result address width
- DP_LATENCY, 2, cycles from `dp_enable` to a valid `dp_result` (engine is fully pipelined, 1 op/cycle)

Ports, with clock and reset first:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared
- start  in  1  batch request, sampled only in IDLE
- abort  in  1  cancels the running batch
- batch_size  in  ADDR_W  number of samples, legal 1..BATCH_MAX, sampled with start
- theta  in  VW  weight vector, latched on accepted start
- busy  out  1  high while a batch is in progress
- done  out  1  one-cycle pulse after the last result write
- err  out  1  one-cycle pulse on rejected start
- smp_rd_en  out  1  sample memory read strobe
- smp_rd_addr  out  ADDR_W  sample index
- smp_rd_data  in  VW  memory data, valid 1 cycle after smp_rd_en
- dp_enable  out  1  issue strobe to the engine
- dp_inp1  out  VW  feature vector (= smp_rd_data)
- dp_inp2  out  VW  latched theta
- dp_result  in  ACC_WIDTH  engine output
- res_wr_en  out  1  result buffer write strobe
- res_wr_addr  out  ADDR_W  result index
- res_wr_data  out  ACC_WIDTH  = dp_result
- batch_sum  out  ACC_WIDTH+ADDR_W  sum of batch results (see Configuration)

## Operation
- States:
  - IDLE: waits for `start`.
  - FETCH: issues memory reads.
  - DRAIN: waits for in-flight results to return.
  - FIN: emits `done`, then returns to IDLE.
- IDLE -> FETCH on `start` with a legal `batch_size` (N).
  - On this transition: latch N and theta, clear the read counter, clear the write counter and `batch_sum`.
- Rejected start: `batch_size` == 0 or > BATCH_MAX.
  - `err` pulses the next cycle; state stays IDLE; no memory access.
- FETCH: `smp_rd_en` = 1, `smp_rd_addr` = read counter (0, 1, …, N-1); counter increments each cycle.
  - After address N-1 is issued, go to DRAIN.
- The issue pipeline is a registered shift of `smp_rd_en`.
  - `dp_enable` is asserted the cycle `smp_rd_data` is valid.
  - A valid-bit shift register of depth DP_LATENCY then tracks in-flight operations.
- When the tail bit is set: `res_wr_en` = 1 with `res_wr_addr` = write counter, then the write counter increments.
  - Results are written in sample order; no reordering.
- DRAIN -> FIN once the write counter reaches N (last write done). FIN -> IDLE after one cycle.
- `start` outside IDLE is ignored. Changes on `theta` or `batch_size` mid-batch are ignored.
- `abort` in FETCH or DRAIN:
  - next cycle: state IDLE, all valid bits cleared, `smp_rd_en`/`dp_enable`/`res_wr_en` low;
  - in-flight results are discarded; no `done`; `batch_sum` holds its partial value.
- `abort` and `start` together in IDLE: abort wins, start is dropped, no `err`.

## Timing
- Reset values:
  - `busy`, `done`, `err`, `smp_rd_en`, `dp_enable`, `res_wr_en` = 0;
  - addresses, `dp_inp2`, `batch_sum` = 0;
  - state IDLE.
- `start` accepted at cycle 0.
  - `busy` = 1 from cycle 1 to the last write cycle inclusive.
  - Read of sample k in cycle 1+k.
  - `dp_enable` for sample k in cycle 2+k.
  - Write of sample k in cycle 2+k+DP_LATENCY.
- `done` = 1 in cycle N+2+DP_LATENCY, with `busy` = 0 that cycle.
- Next `start` is accepted in the `done` cycle or later.
- Throughput is one sample per cycle; there are no bubbles within a batch.
- Reset asserted mid-batch clears everything immediately; no `done` or `err`.

## Configuration
- Macro: `MBGD_SCHED_SUM_EN`.
- Defined: `batch_sum` accumulates `res_wr_data` (zero-extended) on every `res_wr_en`.
  - It is cleared on accepted start and is final and stable from the `done` cycle until the next accepted start.
  - Width ACC_WIDTH+ADDR_W, so it cannot overflow for N ≤ BATCH_MAX.
- Undefined: no accumulator is built and `batch_sum` is tied to 0.

## Test plan
- N=4, theta={2,4,0…}, samples equal theta, DP_LATENCY=2 -> reads in cycles 1..4 (addr 0..3), writes in cycles 4..7 (addr 0..3, data 20 each), `done` in cycle 8, `batch_sum`=80 with SUM_EN (0 without).
- `batch_size`=0 and then 20 -> `err` pulse each time, `busy` stays 0, no `smp_rd_en`.
- N=19, all elements 0xFF -> each result 8*255*255=520200, 19 consecutive writes with no gaps, `batch_sum`=9883800.
- N=8, `abort` in cycle 5 -> no writes after cycle 6, no `done`, IDLE in cycle 6; a new start with N=1 completes normally.
- `start` pulsed again in cycle 3 of an N=6 batch, and theta changed mid-batch -> second start ignored, all results use the latched theta.
- Reset asserted in cycle 4 of an N=5 batch -> all outputs 0 asynchronously, no `done`; after reset is released, a start with N=2 gives `done` in cycle 6.

Source files
------------

// File: rtl/mbgd_dot_sched.sv
// Batch scheduler: streams N samples through the pipelined dot-product engine and writes results in order.
// Optional result accumulator on batch_sum is built only when MBGD_SCHED_SUM_EN is defined.
module mbgd_dot_sched #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ELEMS  = 8,
   parameter int ACC_WIDTH  = 19,
   parameter int BATCH_MAX  = 19,
   parameter int ADDR_W     = 5,
   parameter int DP_LATENCY = 2,
   localparam int VW        = DATA_WIDTH * NUM_ELEMS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDR_W-1:0]      batch_size,
   input  logic [VW-1:0]          theta,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   smp_rd_en,
   output logic [ADDR_W-1:0]      smp_rd_addr,
   input  logic [VW-1:0]          smp_rd_data,
   output logic                   dp_enable,
   output logic [VW-1:0]          dp_inp1,
   output logic [VW-1:0]          dp_inp2,
   input  logic [ACC_WIDTH-1:0]   dp_result,
   output logic                   res_wr_en,
   output logic [ADDR_W-1:0]      res_wr_addr,
   output logic [ACC_WIDTH-1:0]   res_wr_data,
   output logic [ACC_WIDTH+ADDR_W-1:0] batch_sum
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] BMAX  = ADDR_W'(BATCH_MAX);

   logic [1:0]            state_q, state_d;
   logic [ADDR_W-1:0]     n_q, n_d;
   logic [VW-1:0]         theta_q, theta_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
   logic                  dp_en_q, dp_en_d;
   logic [DP_LATENCY-1:0] vld_q, vld_d;
   logic [ADDR_W-1:0]     wr_cnt_q, wr_cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  size_ok_s;
   logic                  can_start_s;
   logic                  accept_s;
   logic                  tail_s;
   logic                  last_wr_s;

   // FIN behaves like IDLE for start handling so a new batch can begin in the done cycle
   assign size_ok_s   = (batch_size != '0) && (batch_size <= BMAX);
   assign can_start_s = (state_q == S_IDLE) || (state_q == S_FIN);
   assign accept_s    = can_start_s && start && !abort && size_ok_s;
   assign tail_s      = vld_q[DP_LATENCY-1];
   assign last_wr_s   = tail_s && (wr_cnt_q == (n_q - ONE_A));

   // next-state logic for control, counters and the in-flight pipeline
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      theta_d   = theta_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      dp_en_d   = rd_en_q;
      vld_d     = '0;
      vld_d[0]  = dp_en_q;
      for (int i = 1; i < DP_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
      end
      wr_cnt_d  = tail_s ? (wr_cnt_q + ONE_A) : wr_cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE, S_FIN: begin
            state_d = S_IDLE;
            if (accept_s) begin
               state_d   = S_FETCH;
               n_d       = batch_size;
               theta_d   = theta;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               wr_cnt_d  = '0;
               busy_d    = 1'b1;
            end else if (start && !abort) begin
               err_d = 1'b1;
            end else begin
               err_d = 1'b0;
            end
         end
         S_FETCH: begin
            if (abort) begin
               state_d = S_IDLE;
               rd_en_d = 1'b0;
               dp_en_d = 1'b0;
               vld_d   = '0;
               busy_d  = 1'b0;
            end else if (rd_addr_q == (n_q - ONE_A)) begin
               rd_en_d = 1'b0;
               state_d = S_DRAIN;
            end else begin
               rd_addr_d = rd_addr_q + ONE_A;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d = S_IDLE;
               rd_en_d = 1'b0;
               dp_en_d = 1'b0;
               vld_d   = '0;
               busy_d  = 1'b0;
            end else if (last_wr_s) begin
               state_d = S_FIN;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
            rd_en_d = 1'b0;
            dp_en_d = 1'b0;
            vld_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // control and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         theta_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         dp_en_q   <= 1'b0;
         vld_q     <= '0;
         wr_cnt_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         theta_q   <= theta_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         dp_en_q   <= dp_en_d;
         vld_q     <= vld_d;
         wr_cnt_q  <= wr_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef MBGD_SCHED_SUM_EN
   logic [ACC_WIDTH+ADDR_W-1:0] sum_q, sum_d;

   // running total of written results; an abort leaves the partial value in place
   always_comb begin
      if (accept_s) begin
         sum_d = '0;
      end else if (tail_s) begin
         sum_d = sum_q + {{ADDR_W{1'b0}}, dp_result};
      end else begin
         sum_d = sum_q;
      end
   end

   // accumulator register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign batch_sum = sum_q;
`else
   assign batch_sum = '0;
`endif

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign smp_rd_en   = rd_en_q;
   assign smp_rd_addr = rd_addr_q;
   assign dp_enable   = dp_en_q;
   assign dp_inp1     = smp_rd_data;
   assign dp_inp2     = theta_q;
   assign res_wr_en   = tail_s;
   assign res_wr_addr = wr_cnt_q;
   assign res_wr_data = dp_result;

endmodule

// File: tb/tb_mbgd_dot_sched.sv
// Self-checking bench for mbgd_dot_sched: sample memory and dot-product engine models plus a
// cycle-timeline reference of the expected batch behaviour.
module tb_mbgd_dot_sched;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [4:0]  batch_size = 5'd0;
   logic [63:0] theta = 64'd0;
   logic        busy, done, err, smp_rd_en, dp_enable, res_wr_en;
   logic [4:0]  smp_rd_addr, res_wr_addr;
   logic [63:0] smp_rd_data, dp_inp1, dp_inp2;
   logic [18:0] dp_result, res_wr_data;
   logic [23:0] batch_sum;

   logic [63:0] mem [0:31];
   logic [18:0] p1, p2;
   int tests = 0;
   int fails = 0;

   mbgd_dot_sched dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .batch_size(batch_size), .theta(theta),
      .busy(busy), .done(done), .err(err),
      .smp_rd_en(smp_rd_en), .smp_rd_addr(smp_rd_addr), .smp_rd_data(smp_rd_data),
      .dp_enable(dp_enable), .dp_inp1(dp_inp1), .dp_inp2(dp_inp2), .dp_result(dp_result),
      .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
      .batch_sum(batch_sum)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] dot(input logic [63:0] a, input logic [63:0] b);
      int s;
      logic [7:0] ea, eb;
      s = 0;
      for (int i = 0; i < 8; i++) begin
         ea = a[8*i +: 8];
         eb = b[8*i +: 8];
         s += int'(ea) * int'(eb);
      end
      return s[18:0];
   endfunction

   // sample memory: registered read, data one cycle after the strobe
   always @(posedge clk) begin
      if (smp_rd_en) smp_rd_data <= mem[smp_rd_addr];
   end

   // two-stage dot-product engine
   always @(posedge clk) begin
      p1 <= dot(dp_inp1, dp_inp2);
      p2 <= p1;
   end
   assign dp_result = p2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " err"}, err, 0);
      chk({tag, " rd_en"}, smp_rd_en, 0);
      chk({tag, " rd_addr"}, smp_rd_addr, 0);
      chk({tag, " dp_en"}, dp_enable, 0);
      chk({tag, " wr_en"}, res_wr_en, 0);
      chk({tag, " wr_addr"}, res_wr_addr, 0);
      chk({tag, " dp_inp2"}, dp_inp2, 0);
      chk({tag, " sum"}, batch_sum, 0);
   endtask

   // One batch started in cycle 0; every following cycle is checked against the timeline:
   // read k in 1+k, issue k in 2+k, write k in 2+k+LAT, done in N+2+LAT.
   task automatic run_batch(input int n, input int abort_at, input int restart_at,
                            input int reset_at, input logic [63:0] th);
      int lim;
      logic [63:0] exp_sum;
      logic a_rd, a_dp, a_wr;
      exp_sum = 64'd0;
      lim = (abort_at > 0) ? abort_at : ((reset_at > 0) ? reset_at - 1 : 1000);
      @(negedge clk);
      batch_size = 5'(n);
      theta = th;
      start = 1'b1;
      for (int c = 1; c <= n + LAT + 4; c++) begin
         @(negedge clk);
         start = (c == restart_at);
         batch_size = 5'($urandom_range(1, 19));
         theta = {$urandom, $urandom};
         abort = (c == abort_at);
         if (c == reset_at) begin
            reset = 1'b1;
            #1;
            chk_all_zero($sformatf("rst_mid c%0d", c));
         end
         a_rd = (c >= 1) && (c <= n) && (c <= lim);
         a_dp = (c >= 2) && (c <= n + 1) && (c <= lim);
         a_wr = (c >= 2 + LAT) && (c <= n + 1 + LAT) && (c <= lim);
         chk($sformatf("rd_en c%0d", c), smp_rd_en, a_rd);
         if (a_rd) chk($sformatf("rd_addr c%0d", c), smp_rd_addr, c - 1);
         chk($sformatf("dp_en c%0d", c), dp_enable, a_dp);
         if (a_dp) begin
            chk($sformatf("dp_inp1 c%0d", c), dp_inp1, mem[c-2]);
            chk($sformatf("dp_inp2 c%0d", c), dp_inp2, th);
         end
         chk($sformatf("wr_en c%0d", c), res_wr_en, a_wr);
         if (a_wr) begin
            chk($sformatf("wr_addr c%0d", c), res_wr_addr, c - 2 - LAT);
            chk($sformatf("wr_data c%0d", c), res_wr_data, dot(mem[c-2-LAT], th));
            exp_sum += 64'(dot(mem[c-2-LAT], th));
         end
         chk($sformatf("busy c%0d", c), busy, (c >= 1) && (c <= n + 1 + LAT) && (c <= lim));
         chk($sformatf("done c%0d", c), done, (lim == 1000) && (c == n + 2 + LAT));
         chk($sformatf("err c%0d", c), err, 0);
      end
      abort = 1'b0;
      if (reset_at > 0) begin
         exp_sum = 64'd0;
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
      end
`ifdef MBGD_SCHED_SUM_EN
      chk("batch_sum", batch_sum, exp_sum);
`else
      chk("batch_sum", batch_sum, 0);
`endif
   endtask

   task automatic reject(input logic [4:0] sz);
      @(negedge clk);
      batch_size = sz;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("rej%0d err", sz), err, 1);
      chk($sformatf("rej%0d busy", sz), busy, 0);
      chk($sformatf("rej%0d rd_en", sz), smp_rd_en, 0);
      @(negedge clk);
      chk($sformatf("rej%0d err2", sz), err, 0);
      chk($sformatf("rej%0d busy2", sz), busy, 0);
      chk($sformatf("rej%0d rd_en2", sz), smp_rd_en, 0);
   endtask

   initial begin
      logic [63:0] th;
      for (int i = 0; i < 32; i++) mem[i] = 64'd0;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // N=4, theta elements {2,4,0..}, samples equal theta: each result 20, sum 80
      th = 64'h0000_0000_0000_0402;
      for (int i = 0; i < 4; i++) mem[i] = th;
      chk("dot20", 64'(dot(th, th)), 64'd20);
      run_batch(4, 0, 0, 0, th);

      reject(5'd0);
      reject(5'd20);

      // full batch of saturated elements
      th = {8{8'hFF}};
      for (int i = 0; i < 19; i++) mem[i] = th;
      run_batch(19, 0, 0, 0, th);
`ifdef MBGD_SCHED_SUM_EN
      chk("sum19", batch_sum, 64'd9883800);
`endif

      // abort mid-fetch, then a normal single-sample batch
      for (int i = 0; i < 19; i++) mem[i] = {$urandom, $urandom};
      run_batch(8, 5, 0, 0, {$urandom, $urandom});
      run_batch(1, 0, 0, 0, {$urandom, $urandom});

      // repeated start and theta churn during a batch
      run_batch(6, 0, 3, 0, {$urandom, $urandom});

      // reset in the middle of a batch, then a short batch
      run_batch(5, 0, 0, 4, {$urandom, $urandom});
      run_batch(2, 0, 0, 0, {$urandom, $urandom});

      // abort together with start in IDLE: start dropped, no err
      @(negedge clk);
      batch_size = 5'd3;
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk("abst err", err, 0);
      chk("abst busy", busy, 0);
      chk("abst rd_en", smp_rd_en, 0);
      @(negedge clk);
      chk("abst busy2", busy, 0);

      // random batches
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 19; i++) mem[i] = {$urandom, $urandom};
         run_batch($urandom_range(1, 19), 0, 0, 0, {$urandom, $urandom});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
